// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants and types for the PWM generator.
//   CNT_W_DEF    : default width of the period input, cycle counter and threshold
//   DUTY_W_DEF   : default width of the duty input (percent)
//   DUTY_MAX_DEF : full-scale duty; larger requests clamp to this value
//   cnt_t        : period/count word at the default width
// -----------------------------------------------------------------------------
package pwm_pkg;
  localparam int CNT_W_DEF    = 32;
  localparam int DUTY_W_DEF   = 7;
  localparam int DUTY_MAX_DEF = 100;

  typedef logic [CNT_W_DEF-1:0] cnt_t;
endpackage

// File: rtl/pwm_gen_if.sv
// -----------------------------------------------------------------------------
// pwm_gen_if
// Signal bundle between a PWM consumer (master) and pwm_gen (slave).
//   duty        : requested high time in percent (master -> slave)
//   period      : PWM cycle length in clk cycles (master -> slave)
//   pwm_out     : registered PWM waveform (slave -> master)
//   cycle_start : one-clock strobe on each non-empty cycle load
//                 (present only when PWM_CYCLE_STROBE_EN is defined)
// -----------------------------------------------------------------------------
interface pwm_gen_if
  import pwm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DUTY_W = DUTY_W_DEF
);
  logic [DUTY_W-1:0] duty;
  logic [CNT_W-1:0]  period;
  logic              pwm_out;
`ifdef PWM_CYCLE_STROBE_EN
  logic              cycle_start;

  modport master (output duty, output period, input pwm_out, input cycle_start);
  modport slave  (input duty, input period, output pwm_out, output cycle_start);
`else
  modport master (output duty, output period, input pwm_out);
  modport slave  (input duty, input period, output pwm_out);
`endif
endinterface

// File: rtl/pwm_thresh_calc.sv
// -----------------------------------------------------------------------------
// pwm_thresh_calc
// Combinational high-time calculation: clamps duty to DUTY_MAX, then
// calc = (period * duty_c) / DUTY_MAX with integer truncation.
//   period : PWM cycle length in clk cycles
//   duty   : requested duty in percent (clamped internally)
//   calc   : number of high cycles per PWM cycle, always <= period
// -----------------------------------------------------------------------------
module pwm_thresh_calc
  import pwm_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DUTY_W   = DUTY_W_DEF,
  parameter int DUTY_MAX = DUTY_MAX_DEF
) (
  input  logic [CNT_W-1:0]  period,
  input  logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  calc
);
  localparam int PROD_W = CNT_W + DUTY_W;

  logic [DUTY_W-1:0] duty_c;
  logic [PROD_W-1:0] prod;

  // The product is kept at full width so the division cannot lose high bits;
  // since duty_c <= DUTY_MAX the quotient always fits back into CNT_W.
  always_comb begin
    duty_c = (duty > DUTY_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : duty;
    prod   = PROD_W'(period) * PROD_W'(duty_c);
    calc   = CNT_W'(prod / PROD_W'(DUTY_MAX));
  end
endmodule

// File: rtl/pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
// Free-running PWM generator. Period (clk cycles) and duty (percent) are
// captured only at PWM cycle boundaries, so every output cycle is glitch-free.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : pwm_gen_if.slave (duty, period in; pwm_out out;
//          cycle_start out when PWM_CYCLE_STROBE_EN is defined)
// Optional feature macro: PWM_CYCLE_STROBE_EN adds a one-clock cycle_start
// strobe on every load edge whose loaded period is non-zero.
// -----------------------------------------------------------------------------
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DUTY_W   = DUTY_W_DEF,
  parameter int DUTY_MAX = DUTY_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  pwm_gen_if.slave   bus
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic             pwm_q, pwm_d;
  logic [CNT_W-1:0] calc;
  logic [CNT_W:0]   cnt_inc;
  logic             load;

  pwm_thresh_calc #(
    .CNT_W    (CNT_W),
    .DUTY_W   (DUTY_W),
    .DUTY_MAX (DUTY_MAX)
  ) u_thresh_calc (
    .period (bus.period),
    .duty   (bus.duty),
    .calc   (calc)
  );

  always_comb begin
    // period_q == 0 also covers the first clock after reset.
    load    = (period_q == '0) || (cnt_q >= period_q - CNT_W'(1));
    // One extra bit so cnt + 1 never wraps in the compare below.
    cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

    cnt_d    = cnt_inc[CNT_W-1:0];
    period_d = period_q;
    thresh_d = thresh_q;
    // pwm_out is registered against the count it will accompany next cycle.
    pwm_d    = (cnt_inc < {1'b0, thresh_q});

    if (load) begin
      cnt_d    = '0;
      period_d = bus.period;
      thresh_d = calc;
      pwm_d    = (calc != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      period_q <= '0;
      thresh_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      thresh_q <= thresh_d;
      pwm_q    <= pwm_d;
    end
  end

  assign bus.pwm_out = pwm_q;

`ifdef PWM_CYCLE_STROBE_EN
  logic cycle_start_q, cycle_start_d;

  always_comb begin
    cycle_start_d = load && (bus.period != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_start_q <= 1'b0;
    end else begin
      cycle_start_q <= cycle_start_d;
    end
  end

  assign bus.cycle_start = cycle_start_q;
`endif
endmodule

// File: tb/tb_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_gen
// Self-checking bench for pwm_gen. The reference model turns each captured
// (period, duty) pair into the whole expected waveform of that PWM cycle and
// queues it; each clock consumes one entry, and an empty queue means the
// coming edge is a cycle boundary where new inputs are captured.
// Works with or without PWM_CYCLE_STROBE_EN.
// -----------------------------------------------------------------------------
module tb_pwm_gen;
  import pwm_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // bit 0: expected pwm_out, bit 1: expected cycle_start
  logic [1:0] exp_q[$];

  pwm_gen_if #(.CNT_W(CNT_W_DEF), .DUTY_W(DUTY_W_DEF)) bus ();

  pwm_gen #(
    .CNT_W    (CNT_W_DEF),
    .DUTY_W   (DUTY_W_DEF),
    .DUTY_MAX (DUTY_MAX_DEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected waveform of one PWM cycle from the arithmetic rule.
  task automatic model_load(input cnt_t p, input logic [DUTY_W_DEF-1:0] d);
    longint dc;
    longint t;
    dc = (d > DUTY_MAX_DEF) ? DUTY_MAX_DEF : longint'(d);
    t  = (longint'(p) * dc) / DUTY_MAX_DEF;
    if (p == 0) begin
      exp_q.push_back(2'b00);
    end else begin
      for (longint i = 0; i < longint'(p); i++) begin
        exp_q.push_back({(i == 0), (i < t)});
      end
    end
  endtask

  task automatic tick(input string tag);
    logic [1:0] e;
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
      e = 2'b00;
    end else begin
      if (exp_q.size() == 0) model_load(bus.period, bus.duty);
      e = exp_q.pop_front();
    end
    #1;
    check_eq({tag, "_pwm"}, 64'(bus.pwm_out), 64'(e[0]));
`ifdef PWM_CYCLE_STROBE_EN
    check_eq({tag, "_strobe"}, 64'(bus.cycle_start), 64'(e[1]));
`endif
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  // Run until the model expects the next edge to be a boundary.
  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(tag);
      n++;
    end
    check_eq({tag, "_drain_timeout"}, 64'(exp_q.size() != 0), 64'd0);
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    rst        = 1'b0;
    bus.duty   = '0;
    bus.period = '0;

    // Reset state
    ticks("rst_hold", 3);
    check_eq("rst_cnt",    64'(dut.cnt_q),    64'd0);
    check_eq("rst_period", 64'(dut.period_q), 64'd0);
    check_eq("rst_thresh", 64'(dut.thresh_q), 64'd0);

    // period 10, duty 50: 5 high / 5 low starting on the first clock after release
    bus.period = 10;
    bus.duty   = 50;
    rst        = 1'b1;
    ticks("p10_d50", 30);

    // Mid-cycle change at cnt = 3 is deferred to the next boundary
    ticks("p10_pre", 4);
    bus.period = 4;
    bus.duty   = 25;
    ticks("p4_d25", 6 + 16);

    // Duty boundaries with period 8
    drain("p4_drain", 20);
    bus.period = 8;
    bus.duty   = 0;
    ticks("p8_d0", 16);
    bus.duty   = 100;
    ticks("p8_d100", 16);
    bus.duty   = 120;
    ticks("p8_d120", 16);
    check_eq("p8_d120_thresh", 64'(dut.thresh_q), 64'd8);

    // period 0 then period 1
    drain("p8_drain", 20);
    bus.period = 0;
    bus.duty   = 50;
    ticks("p0", 10);
    check_eq("p0_cnt", 64'(dut.cnt_q), 64'd0);
    bus.period = 1;
    bus.duty   = 100;
    ticks("p1_d100", 10);
    bus.duty   = 99;
    ticks("p1_d99", 5);

    // Asynchronous reset at cnt = 6
    bus.period = 10;
    bus.duty   = 50;
    ticks("p10_reload", 2);
    drain("p10_sync", 20);
    tick("p10_load");
    n = 0;
    while (exp_q.size() != 3 && n < 20) begin
      tick("p10_run");
      n++;
    end
    check_eq("p10_cnt6", 64'(dut.cnt_q), 64'd6);
    rst = 1'b0;
    #1;
    check_eq("async_rst_pwm", 64'(bus.pwm_out), 64'd0);
    check_eq("async_rst_cnt", 64'(dut.cnt_q),   64'd0);
    ticks("rst_mid", 2);
    rst = 1'b1;
    ticks("p10_restart", 40);

    // 392 Hz tone: threshold and the start of the long cycle
    drain("tone_sync", 20);
    bus.period = 127551;
    bus.duty   = 50;
    tick("tone_load");
    check_eq("tone_thresh", 64'(dut.thresh_q), 64'd63775);
    check_eq("tone_period", 64'(dut.period_q), 64'd127551);
    ticks("tone_run", 200);
    rst = 1'b0;
    ticks("tone_rst", 2);
    rst = 1'b1;

    // Randomised inputs with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.period = cnt_t'($urandom_range(0, 20));
        bus.duty   = 7'($urandom_range(0, 127));
      end
      if (rst && $urandom_range(0, 299) == 0) rst = 1'b0;
      else if (!rst && $urandom_range(0, 2) == 0) rst = 1'b1;
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- Free-running PWM generator; period in clock cycles, duty in percent.
- Frequency sets the tone; duty sets the level.
- Consumed by the music tone generator, which drives period = 50_000_000 / note_hz and duty = 50.
- New period/duty values take effect only at PWM cycle boundaries, so every output cycle is glitch-free.

Parameters:
- CNT_W, 32, width of period input, cycle counter and threshold.
- DUTY_W, 7, width of the duty input (percent).
- DUTY_MAX, 100, full-scale duty; larger inputs clamp to this value.

Ports:
- clk, input, 1, system clock (50 MHz in the product).
- rst, input, 1, asynchronous active-low reset.
- duty, input, DUTY_W, requested high time in percent, 0..DUTY_MAX.
- period, input, CNT_W, PWM cycle length in clk cycles.
- pwm_out, output, 1, registered PWM waveform.

Behaviour:
- Reset (rst low, asynchronous):
  - cnt = 0, period_q = 0, thresh_q = 0, pwm_out = 0.
  - All held while rst is low.
- Load condition: period_q == 0, or cnt >= period_q - 1. This covers the last cycle of a PWM period, and the first clock after reset because period_q is then 0.
- Threshold calculation:
  - duty_c = min(duty, DUTY_MAX).
  - calc = (period * duty_c) / DUTY_MAX, integer truncation.
  - Product computed at CNT_W + DUTY_W bits; the result is guaranteed to be <= period.
- On a load edge:
  - period_q <= period, thresh_q <= calc, cnt <= 0.
  - pwm_out <= (calc > 0).
- On any other edge:
  - cnt <= cnt + 1.
  - pwm_out <= (cnt + 1 < thresh_q).
- Alignment: pwm_out always equals (cnt < thresh_q) for the current cnt, so the output is high for exactly thresh_q of every period_q cycles.
- Changes to period or duty mid-cycle are ignored until the next load edge. Only the values present on that edge are captured.
- Boundary cases:
  - period == 0: load every cycle, cnt stays 0, pwm_out stays 0.
  - period == 1: reload every cycle; pwm_out is constant 1 iff duty_c == DUTY_MAX, else constant 0.
  - duty == 0: output constantly 0.
  - duty >= DUTY_MAX: output constantly 1, provided period >= 1.
- Reset mid-cycle: immediate return to the reset values; the first clock after release performs a load.
- No handshake. Inputs are level-sampled only on load edges and must be synchronous to clk.

Optional Feature:
- Macro: PWM_CYCLE_STROBE_EN.
- When defined:
  - Extra output cycle_start (1 bit).
  - Registered; high for exactly one clk on each load edge where the loaded period_q != 0.
  - Reset value 0.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package pwm_pkg holds:
  - Default widths CNT_W = 32 and DUTY_W = 7.
  - DUTY_MAX = 100.
  - A typedef for the period/count word.
- One natural sub-module, pwm_thresh_calc: purely combinational clamp, multiply and divide-by-DUTY_MAX, producing calc from period and duty.
- Counter, shadow registers and output register stay in pwm_gen.

Test Plan:
- period = 10, duty = 50 after reset release → repeating pattern of 5 cycles high then 5 low; first high cycle is the first clock after release.
- period = 127551 (392 Hz at 50 MHz), duty = 50 → thresh_q = 63775; high 63775 cycles, low 63776 cycles, repeating.
- period = 8 with duty = 0, then duty = 100, then duty = 120 → constant 0; then constant 1 from the next boundary; duty 120 clamps to 100 and gives constant 1.
- period = 10, duty = 50, switch to period = 4, duty = 25 at cnt = 3 → the current cycle completes as 5 high / 5 low; afterwards the pattern is 1 high / 3 low.
- period = 0 → pwm_out stays 0 and cnt stays 0; then period = 1 with duty = 100 → pwm_out constant 1.
- rst pulsed low at cnt = 6 (period = 10, duty = 50) → pwm_out = 0 immediately; after release, the 5-high / 5-low pattern restarts from cnt = 0. With PWM_CYCLE_STROBE_EN defined, cycle_start pulses once every 10 cycles.
